// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor magnitude when it fits.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] q,
  input  logic [DATA_WIDTH-1:0] dmag,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] q_next
);

  logic [DATA_WIDTH:0] partial;
  logic [DATA_WIDTH:0] trial;

  always_comb begin
    partial = {rem, q[DATA_WIDTH-1]};
    trial   = partial - {1'b0, dmag};
    if (!trial[DATA_WIDTH]) begin
      rem_next = trial[DATA_WIDTH-1:0];
      q_next   = {q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      // partial < dmag here, so it always fits back into DATA_WIDTH bits
      rem_next = partial[DATA_WIDTH-1:0];
      q_next   = {q[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with E-stage stall.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rem_q, q_q, dmag_q, result_q;
  logic                  is_rem_q, sign_q, sign_r;

  div_op_e               op_e;
  logic                  signed_op, sa, sb, div_zero, ovf, early, special, issue;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, spec_q, spec_r;
  logic [DATA_WIDTH-1:0] rem_nx, q_nx, q_fix, r_fix;

  assign op_e      = div_op_e'(op);
  assign signed_op = (op_e == DIV) || (op_e == REM);
  assign sa        = signed_op & dividend[DATA_WIDTH-1];
  assign sb        = signed_op & divisor[DATA_WIDTH-1];
  assign a_mag     = sa ? -dividend : dividend;
  assign b_mag     = sb ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = signed_op && (dividend == DIV_OVF_DIVIDEND) && (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early     = !div_zero && (a_mag < b_mag);
`else
  assign early     = 1'b0;
`endif
  assign special   = div_zero | ovf | early;
  assign issue     = start && !flush;

  always_comb begin
    spec_q = '0;
    spec_r = dividend;
    if (div_zero) begin
      spec_q = '1;
    end else if (ovf) begin
      spec_q = DIV_OVF_DIVIDEND;
      spec_r = '0;
    end
  end

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .q        (q_q),
    .dmag     (dmag_q),
    .rem_next (rem_nx),
    .q_next   (q_nx)
  );

  assign q_fix = sign_q ? -q_nx : q_nx;
  assign r_fix = sign_r ? -rem_nx : rem_nx;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          stall   = 1'b1;
          state_d = special ? DONE : RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (flush)                     state_d = IDLE;
        else if (cnt_q == CNT_W'(1))   state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      dmag_q   <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            is_rem_q <= op[1];
            sign_q   <= sa ^ sb;
            sign_r   <= sa;
            dmag_q   <= b_mag;
            if (special) begin
              result_q <= op[1] ? spec_r : spec_q;
            end else begin
              rem_q <= '0;
              q_q   <= a_mag;
              cnt_q <= CNT_W'(DATA_WIDTH);
            end
          end
        end
        RUN: begin
          if (!flush) begin
            rem_q <= rem_nx;
            q_q   <= q_nx;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) result_q <= is_rem_q ? r_fix : q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
